// File: rtl/stack_reg.sv
// Register stack holding the top DEPTH cells of the Forth datapath.
// Cell 0 is T and cell 1 is N. The occupancy count and sticky error flags are
// kept alongside the cells. Every operation is decided in one combinational
// block, and each cell is a plain register.

module stack_cell #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // One data cell; reset clears it immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule

module stack_reg #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D_In,
  input  logic [2:0]       Op_F,
  input  logic             Clr_F,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] N,
  output logic [DW-1:0]    Depth,
  output logic             Full,
  output logic             Empty,
  output logic             Ovf,
  output logic             Unf
);
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_PUSH = 3'd2;
  localparam logic [2:0] OP_POP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_OVER = 3'd6;

  logic [DEPTH-1:0][WIDTH-1:0] cell_q, cell_d;
  logic [DW-1:0]               depth_q, depth_d;
  logic                        ovf_q, unf_q;
  logic                        set_ovf, set_unf;
  logic                        push_en, pop_en;
  logic [WIDTH-1:0]            push_val;
  logic                        is_full, is_empty, lt2;

  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);
  assign lt2      = (depth_q < DW'(2));

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_cell
      stack_cell #(.WIDTH(WIDTH)) u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cell_d[g]),
        .q    (cell_q[g])
      );
    end
  endgenerate

  // Decode the operation. Failed operations raise only a flag, and underflow
  // is tested before overflow so that at most one flag sets per cycle.
  always_comb begin
    cell_d   = cell_q;
    depth_d  = depth_q;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    push_val = D_In;
    case (Op_F)
      OP_LOAD: begin
        cell_d[0] = D_In;
        if (is_empty) depth_d = DW'(1);
      end
      OP_PUSH: begin
        if (is_full) set_ovf = 1'b1;
        else         push_en = 1'b1;
      end
      OP_POP: begin
        if (is_empty) set_unf = 1'b1;
        else          pop_en  = 1'b1;
      end
      OP_SWAP: begin
        if (lt2) set_unf = 1'b1;
        else begin
          cell_d[0] = cell_q[1];
          cell_d[1] = cell_q[0];
        end
      end
      OP_DUP: begin
        if (is_empty)     set_unf = 1'b1;
        else if (is_full) set_ovf = 1'b1;
        else begin
          push_en  = 1'b1;
          push_val = cell_q[0];
        end
      end
      OP_OVER: begin
        if (lt2)          set_unf = 1'b1;
        else if (is_full) set_ovf = 1'b1;
        else begin
          push_en  = 1'b1;
          push_val = cell_q[1];
        end
      end
      default: ;
    endcase
    if (push_en) begin
      for (int i = 1; i < DEPTH; i++) cell_d[i] = cell_q[i-1];
      cell_d[0] = push_val;
      depth_d   = depth_q + DW'(1);
    end
    if (pop_en) begin
      for (int i = 0; i < DEPTH-1; i++) cell_d[i] = cell_q[i+1];
      cell_d[DEPTH-1] = '0;
      depth_d         = depth_q - DW'(1);
    end
  end

  // Occupancy and sticky flags. A flag set this cycle wins over Clr_F.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= set_ovf | (ovf_q & ~Clr_F);
      unf_q   <= set_unf | (unf_q & ~Clr_F);
    end
  end

  assign T     = is_empty ? '0 : cell_q[0];
  assign N     = lt2      ? '0 : cell_q[1];
  assign Depth = depth_q;
  assign Full  = is_full;
  assign Empty = is_empty;
  assign Ovf   = ovf_q;
  assign Unf   = unf_q;
endmodule

// File: tb/tb_stack_reg.sv
// Directed bench for stack_reg (WIDTH=3, DEPTH=4) with hand-computed expectations.
module tb_stack_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] D_In = '0;
  logic [2:0] Op_F = '0;
  logic       Clr_F = 1'b0;
  logic [2:0] T, N, Depth;
  logic       Full, Empty, Ovf, Unf;
  int errors = 0;
  int checks = 0;

  stack_reg #(.WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .D_In(D_In), .Op_F(Op_F), .Clr_F(Clr_F),
    .T(T), .N(N), .Depth(Depth), .Full(Full), .Empty(Empty), .Ovf(Ovf), .Unf(Unf)
  );

  always #5 clk = ~clk;

  // Apply one operation for exactly one rising edge, then settle past the edge
  task automatic step(input logic [2:0] op, input logic [2:0] d, input logic c);
    @(negedge clk);
    Op_F = op; D_In = d; Clr_F = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; Op_F = 3'd0; Clr_F = 1'b0; D_In = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; Op_F = 3'd2; D_In = 3'd5; Clr_F = 1'b0;
    @(posedge clk); #1;
    checks++; if (T !== 3'd0)     begin errors++; $display("FAIL rst_T got=%0d exp=0", T); end
    checks++; if (N !== 3'd0)     begin errors++; $display("FAIL rst_N got=%0d exp=0", N); end
    checks++; if (Depth !== 3'd0) begin errors++; $display("FAIL rst_Depth got=%0d exp=0", Depth); end
    checks++; if ({Empty, Full, Ovf, Unf} !== 4'b1000) begin errors++; $display("FAIL rst_flags got=%b exp=1000", {Empty, Full, Ovf, Unf}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (T !== 3'd5)     begin errors++; $display("FAIL rel_T got=%0d exp=5", T); end
    checks++; if (Depth !== 3'd1) begin errors++; $display("FAIL rel_Depth got=%0d exp=1", Depth); end
  endtask

  task automatic test_push_pop();
    logic [2:0] exp_t;
    do_reset();
    for (int i = 1; i <= 4; i++) step(3'd2, 3'(i), 1'b0);
    checks++; if (T !== 3'd4 || N !== 3'd3) begin errors++; $display("FAIL push_TN got=%0d/%0d exp=4/3", T, N); end
    checks++; if (Depth !== 3'd4 || Full !== 1'b1) begin errors++; $display("FAIL push_full got=%0d/%b exp=4/1", Depth, Full); end
    step(3'd2, 3'd7, 1'b0);
    checks++; if (T !== 3'd4 || Depth !== 3'd4 || Ovf !== 1'b1) begin errors++; $display("FAIL ovf_push got T=%0d D=%0d O=%b exp 4/4/1", T, Depth, Ovf); end
    for (int i = 3; i >= 0; i--) begin
      step(3'd3, 3'd0, 1'b0);
      exp_t = 3'(i);
      checks++; if (T !== exp_t || Depth !== exp_t) begin errors++; $display("FAIL pop%0d got T=%0d D=%0d exp %0d/%0d", i, T, Depth, exp_t, exp_t); end
    end
    checks++; if (Empty !== 1'b1 || N !== 3'd0) begin errors++; $display("FAIL pop_empty got E=%b N=%0d exp 1/0", Empty, N); end
  endtask

  task automatic test_underflow_clear();
    step(3'd3, 3'd0, 1'b0);
    checks++; if (Unf !== 1'b1 || Depth !== 3'd0) begin errors++; $display("FAIL unf_pop got U=%b D=%0d exp 1/0", Unf, Depth); end
    step(3'd0, 3'd0, 1'b1);
    checks++; if (Unf !== 1'b0 || Ovf !== 1'b0) begin errors++; $display("FAIL clr got U=%b O=%b exp 0/0", Unf, Ovf); end
    step(3'd3, 3'd0, 1'b1);
    checks++; if (Unf !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", Unf); end
  endtask

  task automatic test_swap_over_dup();
    do_reset();
    step(3'd2, 3'd6, 1'b0);
    step(3'd2, 3'd2, 1'b0);
    step(3'd4, 3'd0, 1'b0);
    checks++; if (T !== 3'd6 || N !== 3'd2) begin errors++; $display("FAIL swap got %0d/%0d exp 6/2", T, N); end
    step(3'd6, 3'd0, 1'b0);
    checks++; if (T !== 3'd2 || N !== 3'd6 || Depth !== 3'd3) begin errors++; $display("FAIL over got %0d/%0d D=%0d exp 2/6/3", T, N, Depth); end
    step(3'd5, 3'd0, 1'b0);
    checks++; if (T !== 3'd2 || N !== 3'd2 || Depth !== 3'd4) begin errors++; $display("FAIL dup got %0d/%0d D=%0d exp 2/2/4", T, N, Depth); end
    step(3'd5, 3'd0, 1'b0);
    checks++; if (Ovf !== 1'b1 || Depth !== 3'd4 || Unf !== 1'b0) begin errors++; $display("FAIL dup_full got O=%b D=%0d U=%b exp 1/4/0", Ovf, Depth, Unf); end
    // bottom cells preserved through failed dup: pop down to check order 2,6,2
    step(3'd3, 3'd0, 1'b0);
    checks++; if (T !== 3'd2 || N !== 3'd6) begin errors++; $display("FAIL keep got %0d/%0d exp 2/6", T, N); end
  endtask

  task automatic test_load();
    do_reset();
    step(3'd1, 3'd3, 1'b0);
    checks++; if (T !== 3'd3 || Depth !== 3'd1) begin errors++; $display("FAIL load0 got %0d D=%0d exp 3/1", T, Depth); end
    step(3'd1, 3'd7, 1'b0);
    checks++; if (T !== 3'd7 || Depth !== 3'd1) begin errors++; $display("FAIL load1 got %0d D=%0d exp 7/1", T, Depth); end
    step(3'd4, 3'd0, 1'b0);
    checks++; if (Unf !== 1'b1 || T !== 3'd7 || Depth !== 3'd1) begin errors++; $display("FAIL swap1 got U=%b T=%0d D=%0d exp 1/7/1", Unf, T, Depth); end
    step(3'd7, 3'd5, 1'b0);
    checks++; if (T !== 3'd7 || Unf !== 1'b1) begin errors++; $display("FAIL hold7 got T=%0d U=%b exp 7/1", T, Unf); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(3'd2, 3'd1, 1'b0);
    step(3'd2, 3'd2, 1'b0);
    step(3'd2, 3'd3, 1'b0);
    checks++; if (T !== 3'd3 || N !== 3'd2 || Depth !== 3'd3) begin errors++; $display("FAIL pre_async got %0d/%0d D=%0d exp 3/2/3", T, N, Depth); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (T !== 3'd0 || N !== 3'd0 || Depth !== 3'd0) begin errors++; $display("FAIL async got %0d/%0d D=%0d exp 0/0/0", T, N, Depth); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_underflow_clear();
    test_swap_over_dup();
    test_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stack_reg.md
Name: stack_reg

Overview:
- Parametrised register stack; successor to the single load-enabled P0 register.
- Holds the top DEPTH data cells of the Forth datapath and exposes top (T) and next (N) combinationally from registered state.
- Supports load, push, pop, swap, dup and over operations, with occupancy tracking and sticky overflow/underflow flags for the sequencer.
- Sits between the ALU result bus (D_In) and the ALU operand inputs (T, N).

Parameters:
- WIDTH, 3, data cell width in bits.
- DEPTH, 4, maximum number of cells held (DEPTH >= 2).
- DW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- D_In  input  WIDTH  data for load/push.
- Op_F  input  3  operation select: 0 hold, 1 load T, 2 push, 3 pop, 4 swap, 5 dup, 6 over, 7 hold.
- Clr_F  input  1  synchronous clear of the sticky error flags.
- T  output  WIDTH  top cell; 0 when Depth==0.
- N  output  WIDTH  second cell; 0 when Depth<2.
- Depth  output  DW  number of valid cells, 0..DEPTH.
- Full  output  1  Depth==DEPTH.
- Empty  output  1  Depth==0.
- Ovf  output  1  sticky overflow flag.
- Unf  output  1  sticky underflow flag.

Behaviour:
- Reset is asynchronous and active-low. While rst_n==0: all cells, Depth, Ovf and Unf are 0, so T=N=0, Empty=1, Full=0.
- All state updates on the rising clk edge. Op_F is sampled each cycle; effects are visible on T, N and Depth one cycle later.
- Full, Empty, T and N are derived combinationally from registered state.
- Cells below N keep their values and order except as stated per operation.
- hold (0, 7): no state change.
- load (1):
  - Depth>=1: T <= D_In; Depth unchanged.
  - Depth==0: T <= D_In and Depth <= 1. Load never errors.
- push (2):
  - Depth<DEPTH: all cells shift down one, T <= D_In, Depth+1.
  - Full: no data or Depth change; Ovf <= 1.
- pop (3):
  - Depth>=1: cells shift up one, Depth-1. The vacated bottom cell reads 0.
  - Empty: no change; Unf <= 1.
- swap (4):
  - Depth>=2: T <= N, N <= T.
  - Otherwise: no change; Unf <= 1.
- dup (5):
  - Depth==0: Unf <= 1; no change.
  - Full: Ovf <= 1; no change.
  - Otherwise: push of the current T.
- over (6):
  - Depth<2: Unf <= 1; no change.
  - Full: Ovf <= 1; no change.
  - Otherwise: push of the current N.
- Error precedence: when both Ovf and Unf conditions could apply, Unf takes precedence; only one flag sets per cycle.
- Clr_F==1 clears Ovf and Unf at the edge. If an error occurs in the same cycle, the error's flag is set (set wins over clear); the other flag is cleared.
- Failed operations never modify data or Depth.
- Data is not wrapped or discarded on overflow: the bottom cell is preserved, not dropped.
- Reset asserted mid-operation aborts the operation immediately. Deassertion resumes from the empty state on the next edge.
- Depth arithmetic is unsigned DW-bit and never leaves 0..DEPTH.

Test Plan (WIDTH=3, DEPTH=4):
- Reset with Op_F=2, D_In=5 held → T=0, N=0, Depth=0, Empty=1, Ovf=0, Unf=0. After release, the first edge gives T=5, Depth=1.
- Push 1,2,3,4 → T=4, N=3, Depth=4, Full=1. Fifth push of 7 → T=4, Depth=4, Ovf=1. Four pops then read T=3,2,1,0 with Depth 3,2,1,0.
- Empty: pop → Unf=1, Depth=0. Clr_F=1 with hold → Unf=0. Clr_F=1 with pop on empty → Unf stays 1.
- Push 6, push 2, swap → T=6, N=2. Over → T=2, N=6, Depth=3. Dup → T=2, N=2, Depth=4. Dup again → Ovf=1, Depth=4.
- Load on empty with D_In=3 → T=3, Depth=1. Load D_In=7 → T=7, Depth=1. Swap with Depth=1 → Unf=1, T=7.
- Push 1,2,3, then assert rst_n=0 between edges → T, N, Depth go 0 immediately without waiting for clk.
